// File: rtl/conv_layer_sequencer.sv
// Convolution-layer window sequencer: walks (oc,row,col,ic) and issues one
// window descriptor per point, then waits for all output pixels before pulsing done.
module conv_layer_sequencer #(
   parameter int Size           = 5,
   parameter int H              = 32,
   parameter int W              = 32,
   parameter int input_channel  = 1,
   parameter int output_channel = 6,
   parameter int ADDR_WIDTH     = 16,
   parameter int CH_WIDTH       = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  win_valid,
   input  logic                  win_ready,
   output logic [ADDR_WIDTH-1:0] img_addr,
   output logic [ADDR_WIDTH-1:0] flt_addr,
   output logic [CH_WIDTH-1:0]   bias_sel,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  acc_first,
   output logic                  acc_last,
   input  logic                  res_valid,
   output logic [1:0]            state_dbg
);

   localparam int OH   = H - Size + 1;
   localparam int OW   = W - Size + 1;
   localparam int NOUT = output_channel * OH * OW;

   localparam logic [ADDR_WIDTH-1:0] C_HW   = ADDR_WIDTH'(H * W);
   localparam logic [ADDR_WIDTH-1:0] C_W    = ADDR_WIDTH'(W);
   localparam logic [ADDR_WIDTH-1:0] C_IC   = ADDR_WIDTH'(input_channel);
   localparam logic [ADDR_WIDTH-1:0] C_SS   = ADDR_WIDTH'(Size * Size);
   localparam logic [ADDR_WIDTH-1:0] C_OHOW = ADDR_WIDTH'(OH * OW);
   localparam logic [ADDR_WIDTH-1:0] C_OW   = ADDR_WIDTH'(OW);
   localparam logic [ADDR_WIDTH-1:0] IC_MAX = ADDR_WIDTH'(input_channel - 1);
   localparam logic [ADDR_WIDTH-1:0] OW_MAX = ADDR_WIDTH'(OW - 1);
   localparam logic [ADDR_WIDTH-1:0] OH_MAX = ADDR_WIDTH'(OH - 1);
   localparam logic [ADDR_WIDTH-1:0] OC_MAX = ADDR_WIDTH'(output_channel - 1);
   localparam logic [ADDR_WIDTH:0]   C_NOUT = (ADDR_WIDTH + 1)'(NOUT);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] oc, row, col, ic;
   logic [ADDR_WIDTH:0]   res_cnt;
   logic                  hs, ic_wrap, col_wrap, row_wrap, oc_wrap, last_hs, res_full;

   // Handshake: a descriptor transfers on a rising edge where win_valid && win_ready;
   // win_valid stays high and the descriptor stays frozen until that happens.
   assign hs       = (state == S_RUN) && win_ready;
   assign ic_wrap  = (ic == IC_MAX);
   assign col_wrap = (col == OW_MAX);
   assign row_wrap = (row == OH_MAX);
   assign oc_wrap  = (oc == OC_MAX);
   assign last_hs  = hs && ic_wrap && col_wrap && row_wrap && oc_wrap;
   assign res_full = (res_cnt == C_NOUT);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_RUN;
         S_RUN:   if (last_hs) state_nx = S_DRAIN;
         S_DRAIN: if (res_full) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (abort) state_nx = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Loop nest, innermost first: ic, col, row, oc.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         oc  <= '0;
         row <= '0;
         col <= '0;
         ic  <= '0;
      end else if (abort || (state == S_IDLE && start)) begin
         oc  <= '0;
         row <= '0;
         col <= '0;
         ic  <= '0;
      end else if (hs) begin
         if (ic_wrap) begin
            ic <= '0;
            if (col_wrap) begin
               col <= '0;
               if (row_wrap) begin
                  row <= '0;
                  oc  <= oc_wrap ? '0 : oc + 1'b1;
               end else begin
                  row <= row + 1'b1;
               end
            end else begin
               col <= col + 1'b1;
            end
         end else begin
            ic <= ic + 1'b1;
         end
      end
   end

   // Write-back counter; held at zero while idle so every layer starts clean.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_cnt <= '0;
      end else if (abort || state == S_IDLE) begin
         res_cnt <= '0;
      end else if (res_valid && (state == S_RUN || state == S_DRAIN) && !res_full) begin
         res_cnt <= res_cnt + 1'b1;
      end
   end

   assign busy      = (state == S_RUN) || (state == S_DRAIN);
   assign done      = (state == S_DONE);
   assign win_valid = (state == S_RUN);
   assign state_dbg = state;

   assign img_addr  = ic * C_HW + row * C_W + col;
   assign flt_addr  = (oc * C_IC + ic) * C_SS;
   assign bias_sel  = CH_WIDTH'(oc);
   assign out_addr  = oc * C_OHOW + row * C_OW + col;
   assign acc_first = (ic == '0);
   assign acc_last  = ic_wrap;

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Control sequencer for the LeNet FP16 convolution layers. On `start` it walks every (output channel, output row, output column, input channel) point of one layer and issues one window descriptor per point to the MAC/accumulator datapath over a valid/ready handshake. It then waits until all output pixels are written back and pulses `done`. It sits between the layer-level controller and the window-fetch/MAC datapath; C1 uses the default parameters.

## Interface
Parameters:
- `Size`, 5, filter edge length
- `H`, 32, input image height
- `W`, 32, input image width
- `input_channel`, 1, input channels
- `output_channel`, 6, output channels
- `ADDR_WIDTH`, 16, width of all address outputs
- `CH_WIDTH`, 8, width of `bias_sel`

Derived: `OH = H-Size+1`, `OW = W-Size+1`, `NOUT = output_channel*OH*OW`, `NWIN = NOUT*input_channel`.

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `start`  in  1  begin a layer; sampled only in IDLE
- `abort`  in  1  synchronous cancel, any state
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle completion pulse
- `win_valid`  out  1  window descriptor valid
- `win_ready`  in  1  datapath accepts descriptor
- `img_addr`  out  ADDR_WIDTH  `ic*H*W + row*W + col`, window top-left element
- `flt_addr`  out  ADDR_WIDTH  `(oc*input_channel+ic)*Size*Size`
- `bias_sel`  out  CH_WIDTH  `oc`
- `out_addr`  out  ADDR_WIDTH  `oc*OH*OW + row*OW + col`
- `acc_first`  out  1  `ic==0`; clear accumulator and add bias
- `acc_last`  out  1  `ic==input_channel-1`; result complete after this window
- `res_valid`  in  1  datapath wrote one output pixel back

## Operation
- FSM states:
  - IDLE: `start` -> RUN.
  - RUN: the final handshake (oc,row,col,ic all at maximum) -> DRAIN.
  - DRAIN: `res_cnt` reaches NOUT -> DONE.
  - DONE: -> IDLE unconditionally.
  - `abort` from any state -> IDLE.
- Index registers `oc,row,col,ic` all reset to 0 when entering RUN. Loop order, innermost first: ic, col, row, oc. This makes `out_addr` ascend 0..NOUT-1 in flattened `outputConv` order.
- Advance occurs only on handshake (`win_valid && win_ready`):
  - ic increments.
  - When ic wraps, col increments.
  - When col wraps at OW-1, row increments.
  - When row wraps at OH-1, oc increments.
- Descriptor outputs are pure functions of the index registers, valid in the same cycle as `win_valid`. Use multiply-free incremental address registers or constant multiplies; both are acceptable if the values match exactly. All addresses are unsigned; overflow of ADDR_WIDTH is a configuration error and is not checked.
- `win_valid` = 1 only in RUN. Once asserted it is not withdrawn until the handshake completes. Descriptor is stable while `win_valid && !win_ready`.
- `res_cnt`:
  - Counts `res_valid` in RUN and DRAIN, and saturates at NOUT.
  - `res_valid` is ignored in IDLE and DONE.
  - A `res_valid` in the same cycle as the final handshake is counted.
- DRAIN with `res_cnt` already equal to NOUT on entry: go to DONE on the next cycle.
- `start` outside IDLE is ignored. `abort` together with `start` in IDLE: abort wins, stay IDLE.
- `abort`: next cycle in IDLE, indices and `res_cnt` cleared, no `done` pulse.
- `reset` asserted mid-operation: immediate IDLE, all state cleared.

## Timing
- Reset values: `busy=0`, `done=0`, `win_valid=0`, `img_addr=0`, `flt_addr=0`, `bias_sel=0`, `out_addr=0`, `acc_first=1`, `acc_last=(input_channel==1)`.
- `start` at edge N -> RUN at N+1: `win_valid=1` and `busy=1` with the descriptor for index (0,0,0,0).
- With `win_ready` held high: one descriptor per cycle, NWIN consecutive cycles, no bubbles.
- Final handshake at edge M -> DRAIN at M+1 (`win_valid=0`, `busy=1`).
- `res_cnt` reaches NOUT at edge K -> DONE at K+1 (`done=1`, `busy=0`) -> IDLE at K+2.
- `busy`, `done` and `win_valid` are all decoded from registered state; no combinational path from inputs to outputs.

## Test plan
- Reset: drive `reset=0` mid-RUN -> all outputs at reset values immediately. After release, remain IDLE with `win_valid=0`.
- H=W=6, Size=3, input_channel=2, output_channel=2, `win_ready=1`: `start` -> 64 back-to-back descriptors.
  - Descriptor 0: img 0, flt 0, first=1, last=0.
  - Descriptor 1: img 36, flt 9, first=0, last=1.
  - Descriptor 2: img 1, out 1.
  - Descriptor 32: flt 18, bias_sel 1, out 16.
  - Then 32 `res_valid` pulses -> `done` pulses exactly one cycle after the 32nd is sampled.
- Same config, `win_ready` randomly toggled: descriptor held stable during every stall; sequence identical to the previous scenario; `done` after the 32nd result.
- Default LeNet C1: 4704 handshakes. Last descriptor: img 891, flt 125, bias_sel 5, out 4703. 4704 results -> `done`.
- `abort` after 10 handshakes -> IDLE next cycle, no `done`. Re-`start` -> first descriptor is all-zero indices.
- `start` pulsed during RUN and DRAIN is ignored. `res_valid` coincident with the final handshake is counted. Extra `res_valid` beyond NOUT does not disturb the single `done` pulse.
